axil_cam_regs: RTL and testbench
================================

AXIL_CAM_REGS -- requirements
Module: axil_cam_regs

Interface
REQ-001 The block SHALL be an AXI4-Lite responder (slave) register bank for the camera pipeline, driven by an AXI4-Lite initiator.
REQ-002 C_S_AXI_DATA_WIDTH SHALL default to 32 and sets the data bus width in bits; only 32 is supported.
REQ-003 C_S_AXI_ADDR_WIDTH SHALL default to 5 and sets the byte-address width (8 words).
REQ-004 VERSION SHALL default to 32'h0001_0000 and is the read-only version word.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 The clock and reset ports SHALL be:
- S_AXI_ACLK  in  1  clock, all logic on the rising edge
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
REQ-007 The AXI4-Lite ports SHALL be:
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1
- S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  32
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1
- S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2
- S_AXI_BVALID  out  1
- S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  5
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1
- S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  32
- S_AXI_RRESP  out  2
- S_AXI_RVALID  out  1
- S_AXI_RREADY  in  1
REQ-008 The user-side ports SHALL be:
- reg0_out..reg3_out  out  32 each  RW register contents
- status_in  in  32  camera status, synchronous to S_AXI_ACLK
- irq_set  in  1  single-cycle frame-done pulse
- irq  out  1  level interrupt

Function
REQ-009 The register map SHALL be decoded on ADDR[4:2], ignoring ADDR[1:0]:
- 0x00-0x0C: reg0-reg3, RW
- 0x10: status_in, RO, sampled at the AR handshake
- 0x14: VERSION, RO
- 0x18: bit0 is irq_pending (write-1-to-clear); bits 31:1 read 0
- 0x1C: unmapped
REQ-010 RW register writes SHALL honour WSTRB per byte; unstrobed bytes are unchanged.
REQ-011 Writes to 0x10, 0x14 and 0x1C SHALL have no effect and return BRESP=SLVERR (2'b10); all other writes SHALL return OKAY.
REQ-012 Reads of 0x1C SHALL return RDATA=0 with RRESP=SLVERR; all other reads SHALL return OKAY.
REQ-013 The write path SHALL be an FSM with states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP, so AW and W may complete in either order or in the same cycle.
REQ-014 S_AXI_AWREADY SHALL be high only in W_IDLE and W_HAVE_DATA.
REQ-015 S_AXI_WREADY SHALL be high only in W_IDLE and W_HAVE_ADDR.
REQ-016 When the second of the AW and W handshakes completes in cycle N, the register SHALL update and S_AXI_BVALID SHALL rise at the edge ending cycle N, and the FSM SHALL enter W_RESP.
REQ-017 In W_RESP, BVALID and BRESP SHALL stay stable until BREADY=1, then return to W_IDLE; no AW or W SHALL be accepted while in W_RESP.
REQ-018 The read path SHALL accept AR (ARREADY=1) only while RVALID=0.
REQ-019 RDATA and RRESP SHALL be registered at the AR handshake edge, so RVALID rises one cycle after ARVALID&&ARREADY.
REQ-020 RDATA, RRESP and RVALID SHALL stay stable until RREADY=1.
REQ-021 The read and write paths SHALL be independent.
REQ-022 A read whose AR handshake edge coincides with a write commit edge to the same register SHALL return the pre-write value.
REQ-023 irq_pending SHALL set on irq_set and clear on a write to 0x18 with WDATA[0]=1 and WSTRB[0]=1; if both occur on the same edge, set SHALL win.
REQ-024 irq SHALL equal irq_pending AND reg0[0] (interrupt enable), registered.

Reset
REQ-025 On S_AXI_ARESETN=0, the following SHALL clear immediately and asynchronously: reg0-reg3, irq_pending, irq, BVALID, RVALID, BRESP, RRESP, RDATA, AWREADY, WREADY and ARREADY; the write FSM SHALL return to W_IDLE.
REQ-026 A transaction in progress at reset SHALL be discarded without a response.
REQ-027 The READY outputs SHALL first go high at the first rising edge after reset deassertion.

Verification
REQ-028 Write 1,2,3,4 to 0x00,0x04,0x08,0x0C, then read all four back -> RDATA 1,2,3,4, all responses OKAY, reg0_out..reg3_out match.
REQ-029 W handshake 3 cycles before AW to 0x04 with WDATA=0xAABBCCDD and WSTRB=4'b0101 over prior 0x11223344 -> reg1=0x11BB33DD; BVALID rises 1 cycle after AW; BREADY held low 4 cycles keeps BVALID high and AWREADY/WREADY low.
REQ-030 Write 0xFFFFFFFF to 0x14 -> BRESP=SLVERR; read 0x14 -> 0x00010000 OKAY; read 0x1C -> 0 with SLVERR; status_in=0x5A -> read 0x10 returns 0x5A.
REQ-031 reg0=1, pulse irq_set -> irq=1; write 0x18 with WDATA=1 on the same edge as an irq_set pulse -> pending stays 1; a later write without irq_set -> irq=0.
REQ-032 Assert S_AXI_ARESETN low while BVALID=1 and while RVALID=1 -> both drop immediately, registers read 0 after reset, next transaction completes normally.

Source files
------------

// File: rtl/axil_cam_regs.sv
// rtl/axil_cam_regs.sv - AXI4-Lite register bank for the camera pipeline
//
// Purpose:
//   Register bank for the camera pipeline. It provides four read/write control
//   registers, a status word sampled from the camera, a read-only version word,
//   and a write-1-to-clear frame-done interrupt, all behind an AXI4-Lite
//   responder.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock (rising edge); asynchronous active-low reset
//   S_AXI_AW*, S_AXI_W*         write address and write data channels
//   S_AXI_B*                    write response channel
//   S_AXI_AR*, S_AXI_R*         read address and read data channels
//   reg0_out..reg3_out          contents of the RW registers
//                               (reg0[0] is the interrupt enable)
//   status_in                   camera status, read at 0x10
//   irq_set                     frame-done pulse; sets irq_pending
//   irq                         registered irq_pending & reg0[0]
module axil_cam_regs #(
  parameter int                            C_S_AXI_DATA_WIDTH = 32,
  parameter int                            C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [C_S_AXI_DATA_WIDTH-1:0] VERSION            = 32'h0001_0000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
  input  logic                              irq_set,
  output logic                              irq
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_STATUS  = 3'd4;
  localparam logic [2:0] IDX_VERSION = 3'd5;
  localparam logic [2:0] IDX_IRQ     = 3'd6;
  localparam logic [2:0] IDX_UNMAP   = 3'd7;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  w_state_t w_state_q, w_state_d;

  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic [2:0]        aw_idx_q;
  logic [DW-1:0]     wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              arready_q, rvalid_q;
  logic [1:0]        rresp_q;
  logic [DW-1:0]     rdata_q;

  logic [DW-1:0]     regs_q [4];
  logic              irq_pending_q, irq_q;

  logic              aw_hs, w_hs, ar_hs;
  logic              commit;
  logic [2:0]        wr_idx;
  logic [DW-1:0]     wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_slverr;
  logic              awready_d, wready_d;
  logic              irq_clear;

  logic [2:0]        rd_idx;
  logic [DW-1:0]     rd_mux;
  logic              rvalid_d;

  // Protection bits and byte-lane address bits carry no meaning for this bank.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID & awready_q;
  assign w_hs  = S_AXI_WVALID & wready_q;
  assign ar_hs = S_AXI_ARVALID & arready_q;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0]     old_v,
                                               input logic [DW-1:0]     new_v,
                                               input logic [STRB_W-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Write FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= 3'd0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      // READY is registered from the next state, so it only rises one edge
      // after reset release and drops on the same edge the FSM leaves a
      // state that accepts the channel.
      awready_q <= awready_d;
      wready_q  <= wready_d;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[4:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_slverr ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_HAVE_ADDR;
        else if (w_hs)     w_state_d = W_HAVE_DATA;
      end
      W_HAVE_ADDR: if (w_hs)  w_state_d = W_RESP;
      W_HAVE_DATA: if (aw_hs) w_state_d = W_RESP;
      W_RESP:      if (S_AXI_BREADY) w_state_d = W_IDLE;
      default:     w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM: outputs and commit decode
  // ---------------------------------------------------------------------------
  always_comb begin
    commit    = (w_state_q != W_RESP) && (w_state_d == W_RESP);
    // The half that completes this cycle comes straight off the bus; the
    // half that completed earlier comes from its holding register.
    wr_idx    = aw_hs ? S_AXI_AWADDR[4:2] : aw_idx_q;
    wr_data   = w_hs  ? S_AXI_WDATA       : wdata_q;
    wr_strb   = w_hs  ? S_AXI_WSTRB       : wstrb_q;
    wr_slverr = (wr_idx == IDX_STATUS) || (wr_idx == IDX_VERSION) || (wr_idx == IDX_UNMAP);
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
    irq_clear = commit && (wr_idx == IDX_IRQ) && wr_data[0] && wr_strb[0];
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  // ---------------------------------------------------------------------------
  // RW registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (commit && (wr_idx == 3'(i))) regs_q[i] <= apply_strb(regs_q[i], wr_data, wr_strb);
      end
    end
  end

  assign reg0_out = regs_q[0];
  assign reg1_out = regs_q[1];
  assign reg2_out = regs_q[2];
  assign reg3_out = regs_q[3];

  // ---------------------------------------------------------------------------
  // Interrupt: a new frame-done pulse beats a simultaneous clear so no frame
  // is lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_pending_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      if (irq_set)        irq_pending_q <= 1'b1;
      else if (irq_clear) irq_pending_q <= 1'b0;
      irq_q <= irq_pending_q & regs_q[0][0];
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Read path: single outstanding read. The mux samples the registers before
  // this edge's write commit, so a colliding read returns the old value.
  // ---------------------------------------------------------------------------
  assign rd_idx = S_AXI_ARADDR[4:2];

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = regs_q[rd_idx[1:0]];
      IDX_STATUS:             rd_mux = status_in;
      IDX_VERSION:            rd_mux = VERSION;
      IDX_IRQ:                rd_mux = {{(DW-1){1'b0}}, irq_pending_q};
      default:                rd_mux = '0;
    endcase
  end

  assign rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rvalid_q  <= rvalid_d;
      arready_q <= ~rvalid_d;
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= (rd_idx == IDX_UNMAP) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_cam_regs.sv
// tb/tb_axil_cam_regs.sv - self-checking bench for axil_cam_regs
module tb_axil_cam_regs;

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [31:0] VER    = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] reg_out [4];
  logic [31:0] status_in;
  logic        irq_set;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bexp [$];
  logic [33:0] rexp [$];
  logic [31:0] model [4];

  always #5 clk = ~clk;

  axil_cam_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg0_out      (reg_out[0]),
    .reg1_out      (reg_out[1]),
    .reg2_out      (reg_out[2]),
    .reg3_out      (reg_out[3]),
    .status_in     (status_in),
    .irq_set       (irq_set),
    .irq           (irq)
  );

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit timeout);
    bit aw_done, w_done, aw_now, w_now;
    int n;
    aw_done = 0; w_done = 0; timeout = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge clk); #1; n++;
      if (aw_now) begin awvalid = 0; aw_done = 1; end
      if (w_now)  begin wvalid = 0;  w_done = 1;  end
    end
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid || !aw_done || !w_done) begin
      timeout = 1; awvalid = 0; wvalid = 0;
    end else begin
      resp = bresp;
      @(posedge clk); #1;
    end
    bready = 0;
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit timeout);
    bit done, now;
    int n;
    done = 0; timeout = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1;
    n = 0;
    while (!done && n < 20) begin
      now = arready;
      @(posedge clk); #1; n++;
      if (now) begin arvalid = 0; done = 1; end
    end
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid || !done) begin
      timeout = 1; arvalid = 0;
    end else begin
      d = rdata; resp = rresp; rready = 1;
      @(posedge clk); #1;
      rready = 0;
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {awready, wready, arready, bvalid, rvalid, irq});
    end
    checks++;
    if ({reg_out[0], reg_out[1], reg_out[2], reg_out[3], rdata, bresp, rresp} !== '0) begin
      errors++; $display("FAIL reset_data: got nonzero %h %h %h %h %h", reg_out[0], reg_out[1], reg_out[2], reg_out[3], rdata);
    end
    rst_n = 1;
    #1;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++; $display("FAIL ready_before_edge: got %b want 000", {awready, wready, arready});
    end
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_edge: got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic test_rw_basic();
    logic [1:0] r, e; logic [31:0] d; logic [33:0] er; bit to;
    for (int i = 0; i < 4; i++) begin
      bexp.push_back(OKAY);
      do_write(5'(4 * i), 32'(i + 1), 4'hF, r, to);
      e = bexp.pop_front();
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL basic_bresp[%0d]: got %b to=%0d want %b", i, r, to, e); end
      model[i] = 32'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      rexp.push_back({OKAY, 32'(i + 1)});
      do_read(5'(4 * i), d, r, to);
      er = rexp.pop_front();
      checks++;
      if (to || {r, d} !== er) begin errors++; $display("FAIL basic_read[%0d]: got %b/%h want %h", i, r, d, er); end
      checks++;
      if (reg_out[i] !== 32'(i + 1)) begin errors++; $display("FAIL basic_regout[%0d]: got %h want %h", i, reg_out[i], i + 1); end
    end
  endtask

  task automatic test_wstrb_order();
    logic [1:0] r, e, br; bit to;
    bexp.push_back(OKAY);
    do_write(5'h04, 32'h1122_3344, 4'hF, r, to);
    e = bexp.pop_front();
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL strb_pre_bresp: got %b want %b", r, e); end

    bexp.push_back(OKAY);
    bready = 0; awvalid = 0;
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    checks++;
    if ({awready, wready} !== 2'b10) begin errors++; $display("FAIL have_data_ready: got %b want 10", {awready, wready}); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 5'h04; awvalid = 1;
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early: got %b want 0", bvalid); end
    @(posedge clk); #1;
    awvalid = 0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_after_aw: got %b want 1", bvalid); end
    br = bresp;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bvalid, awready, wready, bresp} !== {3'b100, br}) begin
        errors++; $display("FAIL resp_hold[%0d]: got %b want %b", k, {bvalid, awready, wready, bresp}, {3'b100, br});
      end
      @(posedge clk); #1;
    end
    checks++;
    if (reg_out[1] !== 32'h11BB_33DD) begin errors++; $display("FAIL strb_merge: got %h want 11bb33dd", reg_out[1]); end
    model[1] = 32'h11BB_33DD;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    e = bexp.pop_front();
    checks++;
    if (br !== e) begin errors++; $display("FAIL strb_bresp: got %b want %b", br, e); end
    checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL resp_release: got %b want 011", {bvalid, awready, wready}); end
  endtask

  task automatic test_ro_slverr();
    logic [4:0]  wa [3] = '{5'h14, 5'h10, 5'h1C};
    logic [4:0]  ra [5] = '{5'h14, 5'h1C, 5'h10, 5'h07, 5'h1B};
    logic [33:0] rx [5];
    logic [1:0] r, e; logic [31:0] d; logic [33:0] er; bit to;
    for (int i = 0; i < 3; i++) begin
      bexp.push_back(SLVERR);
      do_write(wa[i], 32'hFFFF_FFFF, 4'hF, r, to);
      e = bexp.pop_front();
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL ro_bresp[%h]: got %b want %b", wa[i], r, e); end
    end
    status_in = 32'h0000_005A;
    rx[0] = {OKAY, VER};
    rx[1] = {SLVERR, 32'h0};
    rx[2] = {OKAY, 32'h0000_005A};
    rx[3] = {OKAY, model[1]};
    rx[4] = {OKAY, 32'h0};
    for (int i = 0; i < 5; i++) begin
      rexp.push_back(rx[i]);
      do_read(ra[i], d, r, to);
      er = rexp.pop_front();
      checks++;
      if (to || {r, d} !== er) begin errors++; $display("FAIL ro_read[%h]: got %b/%h want %h", ra[i], r, d, er); end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (reg_out[i] !== model[i]) begin errors++; $display("FAIL ro_no_side_effect[%0d]: got %h want %h", i, reg_out[i], model[i]); end
    end
  endtask

  task automatic test_irq();
    logic [1:0] r, e; logic [31:0] d; bit to;
    bexp.push_back(OKAY);
    do_write(5'h00, 32'h1, 4'hF, r, to);
    e = bexp.pop_front();
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL irq_en_bresp: got %b want %b", r, e); end
    model[0] = 32'h1;
    irq_set = 1;
    @(posedge clk); #1;
    irq_set = 0;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b want 1", irq); end

    bexp.push_back(OKAY);
    do_write(5'h18, 32'h1, 4'b1110, r, to);
    e = bexp.pop_front();
    checks++;
    if (to || r !== e || irq !== 1'b1) begin errors++; $display("FAIL irq_nostrb_clear: irq=%b resp=%b want 1/%b", irq, r, e); end

    bexp.push_back(OKAY);
    awaddr = 5'h18; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; irq_set = 1;
    checks++;
    if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL irq_race_ready: got %b want 11", {awready, wready}); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; irq_set = 0;
    r = bresp;
    @(posedge clk); #1;
    bready = 0;
    e = bexp.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL irq_race_bresp: got %b want %b", r, e); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins: got %b want 1", irq); end

    rexp.push_back({OKAY, 32'h1});
    do_read(5'h18, d, r, to);
    checks++;
    if (to || {r, d} !== rexp.pop_front()) begin errors++; $display("FAIL irq_pending_read: got %b/%h want 1", r, d); end

    bexp.push_back(OKAY);
    do_write(5'h18, 32'h1, 4'hF, r, to);
    e = bexp.pop_front();
    @(posedge clk); #1;
    checks++;
    if (to || r !== e || irq !== 1'b0) begin errors++; $display("FAIL irq_clear: irq=%b resp=%b want 0/%b", irq, r, e); end

    rexp.push_back({OKAY, 32'h0});
    do_read(5'h18, d, r, to);
    checks++;
    if (to || {r, d} !== rexp.pop_front()) begin errors++; $display("FAIL irq_cleared_read: got %b/%h want 0", r, d); end
  endtask

  task automatic test_collide();
    logic [1:0] r, e; logic [31:0] d; logic [33:0] er; bit to;
    bexp.push_back(OKAY);
    rexp.push_back({OKAY, model[2]});
    awaddr = 5'h08; wdata = 32'h0000_0099; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
    araddr = 5'h08; arvalid = 1; rready = 0;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL collide_ready: got %b want 111", {awready, wready, arready}); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    r = bresp; d = rdata;
    er = rexp.pop_front();
    checks++;
    if ({bvalid, rvalid} !== 2'b11 || {rresp, d} !== er) begin
      errors++; $display("FAIL collide_old_value: got v=%b %b/%h want %h", {bvalid, rvalid}, rresp, d, er);
    end
    @(posedge clk); #1;
    bready = 0;
    e = bexp.pop_front();
    checks++;
    if (r !== e) begin errors++; $display("FAIL collide_bresp: got %b want %b", r, e); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rvalid, arready, rdata} !== {2'b10, er[31:0]}) begin
        errors++; $display("FAIL rdata_hold[%0d]: got %b/%h want 10/%h", k, {rvalid, arready}, rdata, er[31:0]);
      end
      @(posedge clk); #1;
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    model[2] = 32'h0000_0099;
    rexp.push_back({OKAY, model[2]});
    do_read(5'h08, d, r, to);
    checks++;
    if (to || {r, d} !== rexp.pop_front()) begin errors++; $display("FAIL collide_new_value: got %b/%h want 99", r, d); end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r, e; logic [31:0] d; bit to;
    bready = 0; rready = 0;
    awaddr = 5'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 5'h04; arvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    checks++;
    if ({bvalid, rvalid} !== 2'b11) begin errors++; $display("FAIL midflight_setup: got %b want 11", {bvalid, rvalid}); end
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({bvalid, rvalid, awready, wready, arready, irq} !== 6'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset: got %b rdata=%h want 000000/0", {bvalid, rvalid, awready, wready, arready, irq}, rdata);
    end
    checks++;
    if ({reg_out[0], reg_out[1], reg_out[2], reg_out[3]} !== 128'h0) begin
      errors++; $display("FAIL async_reset_regs: got %h %h %h %h want 0", reg_out[0], reg_out[1], reg_out[2], reg_out[3]);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({bvalid, rvalid} !== 2'b00) begin errors++; $display("FAIL discarded_resp: got %b want 00", {bvalid, rvalid}); end
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rexp.push_back({OKAY, 32'h0});
      do_read(5'(4 * i), d, r, to);
      checks++;
      if (to || {r, d} !== rexp.pop_front()) begin errors++; $display("FAIL post_reset_read[%0d]: got %b/%h want 0", i, r, d); end
    end
    bexp.push_back(OKAY);
    do_write(5'h0C, 32'h5555, 4'hF, r, to);
    e = bexp.pop_front();
    checks++;
    if (to || r !== e) begin errors++; $display("FAIL post_reset_write: got %b want %b", r, e); end
    model[3] = 32'h5555;
    rexp.push_back({OKAY, model[3]});
    do_read(5'h0C, d, r, to);
    checks++;
    if (to || {r, d} !== rexp.pop_front()) begin errors++; $display("FAIL post_reset_readback: got %b/%h want 5555", r, d); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r, e; logic [31:0] d, v, mask; logic [33:0] er; logic [3:0] s; bit to; int idx;
    for (int k = 0; k < 10; k++) begin
      idx = $urandom_range(0, 3);
      v   = $urandom;
      s   = 4'($urandom_range(0, 15));
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      model[idx] = (model[idx] & ~mask) | (v & mask);
      bexp.push_back(OKAY);
      do_write(5'(4 * idx), v, s, r, to);
      e = bexp.pop_front();
      checks++;
      if (to || r !== e) begin errors++; $display("FAIL b2b_bresp[%0d]: got %b want %b", k, r, e); end
    end
    for (int i = 0; i < 4; i++) rexp.push_back({OKAY, model[i]});
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), d, r, to);
      er = rexp.pop_front();
      checks++;
      if (to || {r, d} !== er) begin errors++; $display("FAIL b2b_read[%0d]: got %b/%h want %h", i, r, d, er); end
    end
  endtask

  initial begin
    rst_n = 0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0; status_in = '0; irq_set = 0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    test_reset();
    test_rw_basic();
    test_wstrb_order();
    test_ro_slverr();
    test_irq();
    test_collide();
    test_reset_midflight();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
